// File: rtl/ctrl_cnt_mc_if.sv
// ctrl_cnt_mc_if: control/status bundle between the datapath FSM and the
// multi-channel terminal counter. The master drives clears, increments and
// limit loads; the slave (the counter) returns counts and status flags.
interface ctrl_cnt_mc_if #(
  parameter int NCH = 4,
  parameter int CW  = 4
) ();
  logic              cnt_clear;
  logic [NCH-1:0]    ch_clear;
  logic [NCH-1:0]    ch_inc;
  logic              cfg_load;
  logic [NCH*CW-1:0] limit_in;
  logic              cascade_en;
  logic [NCH*CW-1:0] count;
  logic [NCH-1:0]    term;
  logic [NCH-1:0]    wrap;
  logic              all_term;

  modport master (
    output cnt_clear, ch_clear, ch_inc, cfg_load, limit_in, cascade_en,
    input  count, term, wrap, all_term
  );

  modport slave (
    input  cnt_clear, ch_clear, ch_inc, cfg_load, limit_in, cascade_en,
    output count, term, wrap, all_term
  );
endinterface

// File: rtl/ctrl_cnt_mc.sv
// ctrl_cnt_mc: multi-channel run-time programmable terminal counter.
// Each channel counts 1..lim and flags termination. In cascade mode the
// channels form one mixed-radix loop nest, channel 0 being the fastest digit;
// the wrap of a channel ripples into its successor within the same cycle.
module ctrl_cnt_mc #(
  parameter int NCH  = 4,
  parameter int PMAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ctrl_cnt_mc_if.slave bus
);

  localparam int CW = $clog2(PMAX) + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] LIM_DEF = CW'(PMAX);

  logic [CW-1:0]  count_q [NCH];
  logic [CW-1:0]  count_d [NCH];
  logic [CW-1:0]  lim_q   [NCH];
  logic [CW-1:0]  lim_d   [NCH];
  logic [NCH-1:0] term_q, term_d;
  logic [NCH-1:0] wrap_q, wrap_d;
  logic           all_term_q, all_term_d;

  // A zero or out-of-range limit falls back to the default so a channel can
  // never be programmed into a state it cannot terminate from.
  function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
    if ((v == '0) || (v > LIM_DEF)) begin
      return LIM_DEF;
    end
    return v;
  endfunction

  // Next-state for all channels, walked from channel 0 upward so that a wrap
  // can ripple into the next channel as its increment within this cycle.
  always_comb begin
    logic carry;
    logic inc;
    logic at_lim;
    count_d    = count_q;
    lim_d      = lim_q;
    term_d     = '0;
    wrap_d     = '0;
    all_term_d = 1'b0;
    carry      = 1'b0;
    inc        = 1'b0;
    at_lim     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      at_lim = (count_q[i] == lim_q[i]);
      if ((i > 0) && bus.cascade_en) begin
        inc = carry;
      end else begin
        inc = bus.ch_inc[i];
      end
      carry = 1'b0;
      if (bus.cnt_clear || bus.ch_clear[i]) begin
        count_d[i] = ONE;
      end else if (bus.cfg_load) begin
        count_d[i] = ONE;
        lim_d[i]   = sanitise(bus.limit_in[i*CW +: CW]);
      end else begin
        term_d[i] = at_lim;
        if (inc) begin
          if (at_lim) begin
            count_d[i] = ONE;
            wrap_d[i]  = 1'b1;
            carry      = 1'b1;
          end else begin
            count_d[i] = count_q[i] + ONE;
          end
        end
      end
    end
    all_term_d = &term_d;
  end

  // State register: counts, limits and the registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        count_q[i] <= ONE;
        lim_q[i]   <= LIM_DEF;
      end
      term_q     <= '0;
      wrap_q     <= '0;
      all_term_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      lim_q      <= lim_d;
      term_q     <= term_d;
      wrap_q     <= wrap_d;
      all_term_q <= all_term_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_count_out
    assign bus.count[g*CW +: CW] = count_q[g];
  end

  assign bus.term     = term_q;
  assign bus.wrap     = wrap_q;
  assign bus.all_term = all_term_q;

endmodule
